// File: rtl/keypad_scan_history_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | keypad_scan_history_if : keypad column/row and digit-history bundle  |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
interface keypad_scan_history_if #(
  parameter int NUM_DIGITS = 2
);
  logic [3:0]              col;
  logic                    clear;
  logic [3:0]              row;
  logic [4*NUM_DIGITS-1:0] digits;
  logic [3:0]              key_code;
  logic                    new_key;

  modport master (
    output col, clear,
    input  row, digits, key_code, new_key
  );

  modport slave (
    input  col, clear,
    output row, digits, key_code, new_key
  );
endinterface
`default_nettype wire

// File: rtl/keypad_scan_history.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | keypad_scan_history : 4x4 keypad scanner, debouncer, digit history   |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module keypad_scan_history #(
  parameter int NUM_DIGITS      = 2,
  parameter int SCAN_CYCLES     = 1000,
  parameter int DEBOUNCE_CYCLES = 20000
) (
  input  wire logic               clk,
  input  wire logic               reset,
  keypad_scan_history_if.slave    kp
);

  localparam int SCAN_W = $clog2(SCAN_CYCLES);
  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  state_t                  state;
  logic [3:0]              col_m;
  logic [3:0]              col_s;
  logic [3:0]              row_drive;
  logic [SCAN_W-1:0]       scan_cnt;
  logic [DB_W-1:0]         db_cnt;
  logic [3:0]              lat_col;
  logic [3:0]              key_idx;
  logic [4*NUM_DIGITS-1:0] history;
  logic [4*NUM_DIGITS-1:0] history_shifted;
  logic [3:0]              code_out;
  logic                    pulse;
  logic [3:0]              key_decoded;

  function automatic logic [1:0] onehot_index(input logic [3:0] v);
    logic [1:0] idx;
    case (v)
      4'b0010: idx = 2'd1;
      4'b0100: idx = 2'd2;
      4'b1000: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

  // Index is {row, col}; rows top to bottom, columns left to right.
  function automatic logic [3:0] decode(input logic [3:0] idx);
    logic [3:0] code;
    case (idx)
      4'h0: code = 4'h1;
      4'h1: code = 4'h2;
      4'h2: code = 4'h3;
      4'h3: code = 4'hA;
      4'h4: code = 4'h4;
      4'h5: code = 4'h5;
      4'h6: code = 4'h6;
      4'h7: code = 4'hB;
      4'h8: code = 4'h7;
      4'h9: code = 4'h8;
      4'hA: code = 4'h9;
      4'hB: code = 4'hC;
      4'hC: code = 4'hE;
      4'hD: code = 4'h0;
      4'hE: code = 4'hF;
      default: code = 4'hD;
    endcase
    return code;
  endfunction

  assign key_decoded = decode(key_idx);

  generate
    if (NUM_DIGITS == 1) begin : g_single_digit
      assign history_shifted = key_decoded;
    end else begin : g_multi_digit
      assign history_shifted = {history[4*NUM_DIGITS-5:0], key_decoded};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= SCAN;
      col_m     <= 4'b0000;
      col_s     <= 4'b0000;
      row_drive <= 4'b0001;
      scan_cnt  <= '0;
      db_cnt    <= '0;
      lat_col   <= 4'b0000;
      key_idx   <= 4'h0;
      history   <= '0;
      code_out  <= 4'h0;
      pulse     <= 1'b0;
    end else begin
      col_m <= kp.col;
      col_s <= col_m;
      pulse <= 1'b0;

      case (state)
        SCAN: begin
          // The first two counts of a row still carry the previous row's columns.
          if ($onehot(col_s) && (scan_cnt >= SCAN_W'(2))) begin
            lat_col <= col_s;
            key_idx <= {onehot_index(row_drive), onehot_index(col_s)};
            db_cnt  <= '0;
            state   <= DEBOUNCE;
          end else if (scan_cnt == SCAN_W'(SCAN_CYCLES - 1)) begin
            scan_cnt  <= '0;
            row_drive <= {row_drive[2:0], row_drive[3]};
          end else begin
            scan_cnt <= scan_cnt + SCAN_W'(1);
          end
        end
        DEBOUNCE: begin
          if (col_s == lat_col) begin
            if (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
              history  <= history_shifted;
              code_out <= key_decoded;
              pulse    <= 1'b1;
              state    <= HELD;
            end else begin
              db_cnt <= db_cnt + DB_W'(1);
            end
          end else begin
            state <= SCAN;
          end
        end
        HELD: begin
          if (col_s == 4'b0000) begin
            db_cnt <= '0;
            state  <= RELEASE;
          end
        end
        RELEASE: begin
          if (col_s != 4'b0000) begin
            state <= HELD;
          end else if (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
            state <= SCAN;
          end else begin
            db_cnt <= db_cnt + DB_W'(1);
          end
        end
        default: state <= SCAN;
      endcase

      // Clear overrides a push landing on the same edge.
      if (kp.clear) begin
        history <= '0;
      end
    end
  end

  assign kp.row      = row_drive;
  assign kp.digits   = history;
  assign kp.key_code = code_out;
  assign kp.new_key  = pulse;

endmodule
`default_nettype wire

// File: tb/tb_keypad_scan_history.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_keypad_scan_history : keypad model driving the scanner, with a    |
// | history/decode reference model.  Revision 1.0                        |
// +----------------------------------------------------------------------+
module tb_keypad_scan_history;

  localparam int NUM_DIGITS      = 3;
  localparam int SCAN_CYCLES     = 8;
  localparam int DEBOUNCE_CYCLES = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  keypad_scan_history_if #(.NUM_DIGITS(NUM_DIGITS)) kif ();

  keypad_scan_history #(
    .NUM_DIGITS     (NUM_DIGITS),
    .SCAN_CYCLES    (SCAN_CYCLES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .kp   (kif)
  );

  // Physical keypad: a pressed key connects its column only while its row is driven.
  logic       pressed = 1'b0;
  logic [1:0] press_row = 2'd0;
  logic [1:0] press_col = 2'd0;
  logic       raw_en = 1'b0;
  logic [3:0] raw_val = 4'b0000;

  assign kif.col = raw_en ? raw_val
                 : ((pressed && kif.row[press_row]) ? (4'b0001 << press_col) : 4'b0000);

  int vectors = 0;
  int miscompares = 0;
  int pulses = 0;
  logic [3:0] hist[$];

  always @(negedge clk) if (kif.new_key === 1'b1) pulses++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [3:0] keycode(input int r, input int c);
    logic [63:0] m;
    m = 64'hDF0E_C987_B654_A321;
    return m[(r*4+c)*4 +: 4];
  endfunction

  function automatic logic [11:0] model_digits();
    logic [11:0] v;
    v = '0;
    for (int i = 0; i < hist.size(); i++) v[4*i +: 4] = hist[i];
    return v;
  endfunction

  task automatic model_push(input logic [3:0] code);
    hist.push_front(code);
    if (hist.size() > NUM_DIGITS) void'(hist.pop_back());
  endtask

  task automatic wait_pulses(input int target, input int budget, input string tag);
    int n;
    n = 0;
    while (pulses < target && n < budget) begin
      tick(1);
      n++;
    end
    check(tag, pulses, target);
  endtask

  task automatic wait_row_enter(input logic [3:0] target);
    logic [3:0] prev;
    int n;
    logic found;
    prev  = kif.row;
    n     = 0;
    found = 1'b0;
    while (!found && n < 100) begin
      tick(1);
      n++;
      if (kif.row == target && prev != target) found = 1'b1;
      prev = kif.row;
    end
    check("row_reach", found, 1);
  endtask

  task automatic press(input int r, input int c, input int hold, input int rel);
    int base;
    base      = pulses;
    press_row = 2'(r);
    press_col = 2'(c);
    pressed   = 1'b1;
    wait_pulses(base + 1, 200, "press_pulse");
    check("key_code", kif.key_code, keycode(r, c));
    model_push(keycode(r, c));
    tick(hold);
    pressed = 1'b0;
    tick(rel);
    check("single_pulse", pulses, base + 1);
    check("digits", kif.digits, model_digits());
  endtask

  initial begin
    int base;
    int changes;
    logic [3:0] prev_row;

    reset     = 1'b0;
    kif.clear = 1'b0;
    tick(3);
    check("rst_row", kif.row, 4'b0001);
    check("rst_digits", kif.digits, 12'h000);
    check("rst_key_code", kif.key_code, 4'h0);
    check("rst_new_key", kif.new_key, 1'b0);

    // Key 1 stable from before edge 1: pulse only after edge DEBOUNCE_CYCLES+3.
    raw_en  = 1'b1;
    raw_val = 4'b0001;
    reset   = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick(1);
      if (k == 6) check("latency_early", kif.new_key, 1'b0);
      if (k == 7) check("latency_edge", kif.new_key, 1'b1);
      if (k == 7) check("latency_code", kif.key_code, 4'h1);
      if (k == 8) check("latency_width", kif.new_key, 1'b0);
    end
    raw_en = 1'b0;
    model_push(4'h1);
    tick(15);
    check("latency_digits", kif.digits, model_digits());

    kif.clear = 1'b1;
    tick(1);
    kif.clear = 1'b0;
    hist.delete();
    check("clear_digits", kif.digits, 12'h000);

    // Key 6 on its own.
    press(1, 2, 5, 15);
    check("key6_digits", kif.digits, 12'h006);

    // 1, 2, 3, A in sequence.
    base = pulses;
    press(0, 0, 3, 12);
    press(0, 1, 3, 12);
    press(0, 2, 3, 12);
    press(0, 3, 3, 12);
    check("seq_digits", kif.digits, 12'h23A);
    check("seq_pulses", pulses, base + 4);

    // Key 5 with a two-cycle dropout right after detection.
    base = pulses;
    wait_row_enter(4'b0010);
    press_row = 2'd1;
    press_col = 2'd1;
    pressed   = 1'b1;
    tick(3);
    raw_en  = 1'b1;
    raw_val = 4'b0000;
    tick(2);
    raw_en = 1'b0;
    tick(4);
    check("glitch_no_push", pulses, base);
    wait_pulses(base + 1, 60, "glitch_retry_pulse");
    check("glitch_code", kif.key_code, 4'h5);
    model_push(4'h5);
    pressed = 1'b0;
    tick(15);
    check("glitch_single", pulses, base + 1);

    // Key 9 held long, bouncing on release.
    base      = pulses;
    press_row = 2'd2;
    press_col = 2'd2;
    pressed   = 1'b1;
    wait_pulses(base + 1, 200, "bounce_pulse");
    model_push(4'h9);
    tick(100);
    repeat (3) begin
      pressed = 1'b0;
      tick(2);
      pressed = 1'b1;
      tick(3);
    end
    pressed = 1'b0;
    tick(15);
    check("bounce_single", pulses, base + 1);
    check("bounce_digits", kif.digits, model_digits());

    // Two keys in one row: never accepted, scanning continues.
    base     = pulses;
    raw_en   = 1'b1;
    raw_val  = 4'b0011;
    changes  = 0;
    prev_row = kif.row;
    repeat (40) begin
      tick(1);
      if (kif.row != prev_row) changes++;
      prev_row = kif.row;
    end
    raw_en = 1'b0;
    tick(4);
    check("multihot_no_push", pulses, base);
    check("multihot_rotates", (changes >= 4), 1);

    // Random keys with random hold and release durations.
    for (int i = 0; i < 8; i++) begin
      press(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
            int'($urandom_range(0, 20)), int'($urandom_range(12, 24)));
    end

    // Clear landing on the push edge of key E.
    base = pulses;
    wait_row_enter(4'b1000);
    press_row = 2'd3;
    press_col = 2'd0;
    pressed   = 1'b1;
    tick(6);
    kif.clear = 1'b1;
    tick(1);
    kif.clear = 1'b0;
    check("clrpush_new_key", kif.new_key, 1'b1);
    check("clrpush_code", kif.key_code, 4'hE);
    check("clrpush_digits", kif.digits, 12'h000);
    hist.delete();
    pressed = 1'b0;
    tick(15);
    check("clrpush_pulses", pulses, base + 1);
    check("clrpush_hold", kif.digits, model_digits());

    // Reset while a key is held, then the same key re-registers.
    base      = pulses;
    press_row = 2'd2;
    press_col = 2'd1;
    pressed   = 1'b1;
    wait_pulses(base + 1, 200, "held_pulse");
    tick(5);
    reset = 1'b0;
    tick(1);
    check("midrst_row", kif.row, 4'b0001);
    check("midrst_digits", kif.digits, 12'h000);
    check("midrst_new_key", kif.new_key, 1'b0);
    check("midrst_key_code", kif.key_code, 4'h0);
    hist.delete();
    reset = 1'b1;
    wait_pulses(base + 2, 200, "fresh_pulse");
    check("fresh_code", kif.key_code, 4'h8);
    model_push(4'h8);
    pressed = 1'b0;
    tick(15);
    check("fresh_digits", kif.digits, model_digits());

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
